// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate-generator pipeline: format codes and
// the RV32I/RV64I major opcodes the decoder recognises.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side request and ALU-side response of the immediate pipeline.
// slave is the pipeline's view, master is the driver/consumer view.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational format decode and sign-extended immediate extraction.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output fmt_e            o_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [6:0]      w_op;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_op = i_instr[6:0];

    // Every layout sign-extends from instr[31]; the signed cast does the fill.
    assign w_imm_i = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));

    // Opcode to format; unknown opcodes (and the 64-bit-only W forms on RV32)
    // fall through to ILL with a zero immediate.
    always_comb begin
        o_fmt     = FMT_ILL;
        o_imm     = '0;
        o_illegal = 1'b1;
        case (w_op)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                o_fmt = FMT_I; o_imm = w_imm_i; o_illegal = 1'b0;
            end
            OP_IMM32: if (XLEN == 64) begin
                o_fmt = FMT_I; o_imm = w_imm_i; o_illegal = 1'b0;
            end
            OP_STORE: begin
                o_fmt = FMT_S; o_imm = w_imm_s; o_illegal = 1'b0;
            end
            OP_BRANCH: begin
                o_fmt = FMT_B; o_imm = w_imm_b; o_illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt = FMT_U; o_imm = w_imm_u; o_illegal = 1'b0;
            end
            OP_JAL: begin
                o_fmt = FMT_J; o_imm = w_imm_j; o_illegal = 1'b0;
            end
            OP_REG: begin
                o_fmt = FMT_R; o_illegal = 1'b0;
            end
            OP_REG32: if (XLEN == 64) begin
                o_fmt = FMT_R; o_illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: stage 1 holds the decoded
// instruction and its PC, stage 2 holds the result plus the PC-relative target.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    imm_gen_pipe_if.slave  bus
);

    fmt_e            w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_s1_ld, w_s2_ld;

    logic [2:1]      r_vld_pipe;
    fmt_e            r_s1_fmt, r_s2_fmt;
    logic [XLEN-1:0] r_s1_imm, r_s1_pc, r_s2_imm, r_s2_target;
    logic            r_s1_ill, r_s2_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (bus.in_instr),
        .o_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    // A stage loads when empty or when its entry moves on this cycle; the
    // out_ready -> in_ready combinational path lets a full pipe shift in one go.
    assign w_s2_ld      = !r_vld_pipe[2] || bus.out_ready;
    assign w_s1_ld      = !r_vld_pipe[1] || w_s2_ld;
    assign bus.in_ready = w_s1_ld;

    // Valid bits advance together with the data they qualify.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else begin
            if (w_s1_ld) r_vld_pipe[1] <= bus.in_valid;
            if (w_s2_ld) r_vld_pipe[2] <= r_vld_pipe[1];
        end
    end

    // Stage 1 data: only overwritten by a real entry so bubbles leave it quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_fmt <= FMT_R;
            r_s1_imm <= '0;
            r_s1_pc  <= '0;
            r_s1_ill <= 1'b0;
        end else if (w_s1_ld && bus.in_valid) begin
            r_s1_fmt <= w_fmt;
            r_s1_imm <= w_imm;
            r_s1_pc  <= bus.in_pc;
            r_s1_ill <= w_illegal;
        end
    end

    // Stage 2 data: target adds at full width, carry-out drops (mod 2^XLEN).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_fmt    <= FMT_R;
            r_s2_imm    <= '0;
            r_s2_target <= '0;
            r_s2_ill    <= 1'b0;
        end else if (w_s2_ld && r_vld_pipe[1]) begin
            r_s2_fmt    <= r_s1_fmt;
            r_s2_imm    <= r_s1_imm;
            r_s2_target <= r_s1_pc + r_s1_imm;
            r_s2_ill    <= r_s1_ill;
        end
    end

    assign bus.out_valid   = r_vld_pipe[2];
    assign bus.out_imm     = r_s2_imm;
    assign bus.out_fmt     = r_s2_fmt;
    assign bus.out_target  = r_s2_target;
    assign bus.out_illegal = r_s2_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: directed vectors push hand-computed results into a
// per-DUT queue; monitors pop and compare whenever an output is taken.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] target;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk = 0;
    int   err = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t m32, m64;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] imm, input logic [63:0] tgt,
                                input logic [2:0] fmt, input logic ill);
        exp_t e;
        e.imm = imm; e.target = tgt; e.fmt = fmt; e.ill = ill;
        return e;
    endfunction

    // Present one instruction (called at posedge+1) and hold it until taken.
    task automatic send(input bit w64, input logic [31:0] instr,
                        input logic [63:0] pc, input exp_t e);
        bit ok = 0;
        if (w64) begin
            bus64.in_valid = 1'b1; bus64.in_instr = instr; bus64.in_pc = pc;
        end else begin
            bus32.in_valid = 1'b1; bus32.in_instr = instr; bus32.in_pc = pc[31:0];
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w64 ? bus64.in_ready : bus32.in_ready) begin
                if (w64) q64.push_back(e); else q32.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk++; err++;
            $display("FAIL send timeout: in_ready stayed 0 for instr %h", instr);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus32.in_valid = 1'b0;
        bus64.in_valid = 1'b0;
    endtask

    // Monitors: any taken output must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                chk++; err++;
                $display("FAIL d32 unexpected output: got imm=%h expected none", bus32.out_imm);
            end else begin
                m32 = q32.pop_front();
                cmp("d32 imm",    {32'b0, bus32.out_imm},    m32.imm);
                cmp("d32 target", {32'b0, bus32.out_target}, m32.target);
                cmp("d32 fmt",    {61'b0, bus32.out_fmt},    {61'b0, m32.fmt});
                cmp("d32 illegal", {63'b0, bus32.out_illegal}, {63'b0, m32.ill});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                chk++; err++;
                $display("FAIL d64 unexpected output: got imm=%h expected none", bus64.out_imm);
            end else begin
                m64 = q64.pop_front();
                cmp("d64 imm",    bus64.out_imm,    m64.imm);
                cmp("d64 target", bus64.out_target, m64.target);
                cmp("d64 fmt",    {61'b0, bus64.out_fmt}, {61'b0, m64.fmt});
                cmp("d64 illegal", {63'b0, bus64.out_illegal}, {63'b0, m64.ill});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus32.in_valid = 0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1;
        bus64.in_valid = 0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        cmp("rst d32 out_valid", {63'b0, bus32.out_valid}, 64'd0);
        cmp("rst d32 in_ready",  {63'b0, bus32.in_ready},  64'd1);
        cmp("rst d32 out_imm",   {32'b0, bus32.out_imm},   64'd0);
        cmp("rst d32 out_target", {32'b0, bus32.out_target}, 64'd0);
        cmp("rst d32 fmt/ill",   {60'b0, bus32.out_fmt, bus32.out_illegal}, 64'd0);
        cmp("rst d64 out_valid", {63'b0, bus64.out_valid}, 64'd0);
        cmp("rst d64 out_imm",   bus64.out_imm, 64'd0);
        @(posedge clk); #1;

        // lw x1,-4(x2) with latency check: visible exactly two cycles on
        send(0, 32'hFFC12083, 64'h0, mk(64'hFFFF_FFFC, 64'hFFFF_FFFC, 3'd1, 0));
        idle();
        @(negedge clk);
        cmp("latency d32 out_valid N+1", {63'b0, bus32.out_valid}, 64'd0);
        @(negedge clk);
        cmp("latency d32 out_valid N+2", {63'b0, bus32.out_valid}, 64'd1);
        @(posedge clk); #1;

        // Back-to-back stream covering every format on RV32
        send(0, 32'hFE000CE3, 64'h100,  mk(64'hFFFF_FFF8, 64'h0000_00F8, 3'd3, 0)); // beq -8
        send(0, 32'hFE532FA3, 64'h1000, mk(64'hFFFF_FFFF, 64'h0000_0FFF, 3'd2, 0)); // sw -1
        send(0, 32'h12345017, 64'h10,   mk(64'h1234_5000, 64'h1234_5010, 3'd4, 0)); // auipc
        send(0, 32'h00B50533, 64'h8,    mk(64'h0,         64'h8,         3'd0, 0)); // add
        send(0, 32'h0000007F, 64'h40,   mk(64'h0,         64'h40,        3'd7, 1)); // unknown
        send(0, 32'h0000001B, 64'h0,    mk(64'h0,         64'h0,         3'd7, 1)); // OP_IMM32 on RV32
        idle();
        repeat (4) @(posedge clk); #1;

        // Backpressure: two fill the pipe, the third must wait
        bus32.out_ready = 0;
        send(0, 32'h00100093, 64'h0, mk(64'h1, 64'h1, 3'd1, 0));
        send(0, 32'h00200093, 64'h0, mk(64'h2, 64'h2, 3'd1, 0));
        bus32.in_valid = 1; bus32.in_instr = 32'h00300093; bus32.in_pc = '0;
        @(negedge clk);
        cmp("bp d32 in_ready on third", {63'b0, bus32.in_ready}, 64'd0);
        cmp("bp d32 held imm",          {32'b0, bus32.out_imm},  64'd1);
        @(posedge clk); #1;
        bus32.out_ready = 1;
        send(0, 32'h00300093, 64'h0, mk(64'h3, 64'h3, 3'd1, 0));
        idle();
        repeat (4) @(posedge clk); #1;

        // RV64 vectors
        send(1, 32'h800000B7, 64'h0, mk(64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 0));
        send(1, 32'h0200006F, 64'hFFFF_FFFF_FFFF_FFF0, mk(64'h20, 64'h10, 3'd5, 0));
        send(1, 32'h0000001B, 64'h4,   mk(64'h0, 64'h4,   3'd1, 0)); // addiw legal on RV64
        send(1, 32'h0000003B, 64'h100, mk(64'h0, 64'h100, 3'd0, 0)); // addw
        send(1, 32'h0000007F, 64'h0,   mk(64'h0, 64'h0,   3'd7, 1));
        idle();
        repeat (4) @(posedge clk); #1;

        // Reset with both stages full: both entries are discarded
        bus32.out_ready = 0;
        send(0, 32'h00500093, 64'h0, mk(64'h5, 64'h5, 3'd1, 0));
        send(0, 32'h00600093, 64'h0, mk(64'h6, 64'h6, 3'd1, 0));
        idle();
        @(negedge clk);
        cmp("pre-rst d32 in_ready", {63'b0, bus32.in_ready}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q32.delete();
        @(negedge clk);
        cmp("mid-rst d32 out_valid", {63'b0, bus32.out_valid}, 64'd0);
        cmp("mid-rst d32 in_ready",  {63'b0, bus32.in_ready},  64'd1);
        cmp("mid-rst d32 out_imm",   {32'b0, bus32.out_imm},   64'd0);
        bus32.out_ready = 1;
        repeat (6) @(posedge clk); #1;

        // Drain, then every expected entry must have been consumed exactly once
        for (int i = 0; i < 50 && (q32.size() != 0 || q64.size() != 0); i++)
            @(posedge clk);
        cmp("d32 queue drained", 64'(q32.size()), 64'd0);
        cmp("d64 queue drained", 64'(q64.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
